// File: rtl/reservoir_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reservoir_level_ctrl
// Brief    : Debounced thermometer-sensor level decoder driving nominal flow
//            valves (fr) and a supplemental falling-level valve (dfr).
//            Optional macro RESERVOIR_FAULT_EN enables invalid-pattern fault
//            detection with level hold.
// Revision : 1.0 - initial release
// ============================================================================
module reservoir_level_ctrl #(
    parameter int LEVELS   = 3,
    parameter int DEBOUNCE = 1,
    localparam int LW      = $clog2(LEVELS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEVELS-1:0] s,
    output logic [LEVELS-1:0] fr,
    output logic              dfr,
    output logic [LW-1:0]     level,
    output logic              fault
);

    localparam logic [7:0]    c_DEB_MAX = 8'(DEBOUNCE);
    localparam logic [LW-1:0] c_TOP     = LW'(LEVELS);

    logic [LEVELS-1:0] r_cand;
    logic [7:0]        r_cnt;
    logic [LW-1:0]     r_level;
    logic              r_dfr;

    logic [LW-1:0]     w_dec;
    logic [7:0]        w_cnt_next;
    logic              w_accept;

    // Highest covered sensor gives the level; for thermometer codes this is exact.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (s[i]) w_dec = LW'(i + 1);
        end
    end

`ifdef RESERVOIR_FAULT_EN
    logic [LEVELS-1:0] w_inc;
    logic              w_valid;
    logic              r_fault;

    // A thermometer code plus one has no bits in common with itself.
    always_comb begin
        w_inc   = s + LEVELS'(1);
        w_valid = ((w_inc & s) == '0);
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        w_cnt_next = 8'd1;
        if ((s == r_cand) && (r_cnt != 8'd0)) begin
            w_cnt_next = (r_cnt >= c_DEB_MAX) ? c_DEB_MAX : r_cnt + 8'd1;
        end
`ifdef RESERVOIR_FAULT_EN
        if (!w_valid) w_cnt_next = 8'd0;
`endif
        w_accept = (w_cnt_next == c_DEB_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand  <= '0;
            r_cnt   <= 8'd0;
            r_level <= '0;
            r_dfr   <= 1'b1;
`ifdef RESERVOIR_FAULT_EN
            r_fault <= 1'b0;
`endif
        end else begin
            r_cand <= s;
            r_cnt  <= w_cnt_next;
`ifdef RESERVOIR_FAULT_EN
            r_fault <= ~w_valid;
`endif
            if (w_accept) begin
                if (w_dec > r_level) begin
                    r_level <= w_dec;
                    r_dfr   <= 1'b0;
                end else if (w_dec < r_level) begin
                    r_level <= w_dec;
                    r_dfr   <= 1'b1;
                end
            end
        end
    end

    // Empty and full reservoirs force dfr regardless of direction history.
    always_comb begin
        if (r_level == '0)        dfr = 1'b1;
        else if (r_level == c_TOP) dfr = 1'b0;
        else                      dfr = r_dfr;
    end

    always_comb begin
        fr = '0;
        for (int i = 0; i < LEVELS; i++) begin
            fr[i] = (i < (LEVELS - int'(r_level)));
        end
    end

    assign level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_reservoir_level_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservoir_level_ctrl
// Brief    : Scoreboard bench for reservoir_level_ctrl across three
//            LEVELS/DEBOUNCE configurations; fault expectations follow
//            RESERVOIR_FAULT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservoir_level_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] s1, s4;
    logic [7:0] s8;
    logic [2:0] fr1, fr4;
    logic [7:0] fr8;
    logic       dfr1, dfr4, dfr8;
    logic [1:0] level1, level4;
    logic [3:0] level8;
    logic       fault1, fault4, fault8;

    reservoir_level_ctrl #(.LEVELS(3), .DEBOUNCE(1)) u_d1 (
        .clk(clk), .reset(reset), .s(s1), .fr(fr1), .dfr(dfr1), .level(level1), .fault(fault1));
    reservoir_level_ctrl #(.LEVELS(3), .DEBOUNCE(4)) u_d4 (
        .clk(clk), .reset(reset), .s(s4), .fr(fr4), .dfr(dfr4), .level(level4), .fault(fault4));
    reservoir_level_ctrl #(.LEVELS(8), .DEBOUNCE(2)) u_l8 (
        .clk(clk), .reset(reset), .s(s8), .fr(fr8), .dfr(dfr8), .level(level8), .fault(fault8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] level;
        logic [7:0] fr;
        logic       dfr;
        logic       fault;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void push(int lv, logic [7:0] f, logic d, logic flt);
        exp_t e;
        e.level = 4'(lv);
        e.fr    = f;
        e.dfr   = d;
        e.fault = flt;
        q.push_back(e);
    endfunction

    function automatic logic [7:0] exp_fr(int lv, int n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = (i < n - lv);
        return r;
    endfunction

    function automatic exp_t obs(int which);
        exp_t o;
        o = '0;
        case (which)
            1: begin o.level = {2'b0, level1}; o.fr = {5'b0, fr1}; o.dfr = dfr1; o.fault = fault1; end
            4: begin o.level = {2'b0, level4}; o.fr = {5'b0, fr4}; o.dfr = dfr4; o.fault = fault4; end
            default: begin o.level = level8; o.fr = fr8; o.dfr = dfr8; o.fault = fault8; end
        endcase
        return o;
    endfunction

    task automatic test_reset;
        exp_t e, o;
        int   ids[3];
        ids = '{1, 4, 8};
        reset = 1'b1; s1 = '0; s4 = '0; s8 = '0;
        repeat (2) @(posedge clk);
        push(0, 8'h07, 1'b1, 1'b0);
        push(0, 8'h07, 1'b1, 1'b0);
        push(0, 8'hFF, 1'b1, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = q.pop_front();
            o = obs(ids[k]);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset dut%0d: got level=%0d fr=%b dfr=%b fault=%b, want level=%0d fr=%b dfr=%b fault=%b",
                         ids[k], o.level, o.fr, o.dfr, o.fault, e.level, e.fr, e.dfr, e.fault);
            end
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_sequence;
        exp_t       e, o;
        logic [2:0] sv[7];
        int         lv[7];
        logic       dv[7];
        sv = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b011, 3'b001, 3'b000};
        lv = '{0, 1, 2, 3, 2, 1, 0};
        dv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk) s1 = sv[k];
            push(lv[k], exp_fr(lv[k], 3), dv[k], 1'b0);
            @(posedge clk) #1;
            e = q.pop_front();
            o = obs(1);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sequence step%0d: got level=%0d fr=%b dfr=%b fault=%b, want level=%0d fr=%b dfr=%b fault=%b",
                         k, o.level, o.fr, o.dfr, o.fault, e.level, e.fr, e.dfr, e.fault);
            end
        end
    endtask

    task automatic test_debounce;
        exp_t       e, o;
        logic [2:0] sv[12];
        int         lv[12];
        sv = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b001,
               3'b011, 3'b011, 3'b011, 3'b011};
        lv = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2};
        for (int k = 0; k < 12; k++) begin
            @(negedge clk) s4 = sv[k];
            push(lv[k], exp_fr(lv[k], 3), (lv[k] == 0), 1'b0);
            @(posedge clk) #1;
            e = q.pop_front();
            o = obs(4);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL debounce step%0d: got level=%0d fr=%b dfr=%b fault=%b, want level=%0d fr=%b dfr=%b fault=%b",
                         k, o.level, o.fr, o.dfr, o.fault, e.level, e.fr, e.dfr, e.fault);
            end
        end
    endtask

    task automatic test_jump_fall_fault;
        exp_t       e, o;
        logic [2:0] sv[6];
        int         lv[6];
        logic       dv[6];
        logic       fv[6];
`ifdef RESERVOIR_FAULT_EN
        lv = '{3, 1, 2, 2, 2, 2};
        dv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        fv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        lv = '{3, 1, 2, 3, 3, 2};
        dv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        fv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        sv = '{3'b111, 3'b001, 3'b011, 3'b101, 3'b101, 3'b011};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk) s1 = sv[k];
            push(lv[k], exp_fr(lv[k], 3), dv[k], fv[k]);
            @(posedge clk) #1;
            e = q.pop_front();
            o = obs(1);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jump_fault step%0d: got level=%0d fr=%b dfr=%b fault=%b, want level=%0d fr=%b dfr=%b fault=%b",
                         k, o.level, o.fr, o.dfr, o.fault, e.level, e.fr, e.dfr, e.fault);
            end
        end
    endtask

    task automatic test_reset_mid_debounce;
        exp_t e, o;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            s4    = 3'b111;
            reset = (k == 2);
            if (k < 2)       push(2, exp_fr(2, 3), 1'b0, 1'b0);
            else if (k < 6)  push(0, exp_fr(0, 3), 1'b1, 1'b0);
            else             push(3, exp_fr(3, 3), 1'b0, 1'b0);
            @(posedge clk) #1;
            e = q.pop_front();
            o = obs(4);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid step%0d: got level=%0d fr=%b dfr=%b fault=%b, want level=%0d fr=%b dfr=%b fault=%b",
                         k, o.level, o.fr, o.dfr, o.fault, e.level, e.fr, e.dfr, e.fault);
            end
        end
    endtask

    task automatic test_ramp8;
        exp_t e, o;
        int   mlvl, mdfr, tgt;
        mlvl = 0;
        mdfr = 1;
        for (int step = 0; step < 16; step++) begin
            tgt = (step < 8) ? step + 1 : 15 - step;
            for (int h = 0; h < 2; h++) begin
                @(negedge clk) s8 = 8'((1 << tgt) - 1);
                if (h == 1) begin
                    if (tgt > mlvl) mdfr = 0;
                    else if (tgt < mlvl) mdfr = 1;
                    mlvl = tgt;
                end
                push(mlvl, exp_fr(mlvl, 8), (mlvl == 0) ? 1'b1 : (mlvl == 8) ? 1'b0 : mdfr[0], 1'b0);
                @(posedge clk) #1;
                e = q.pop_front();
                o = obs(8);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL ramp8 step%0d.%0d: got level=%0d fr=%b dfr=%b fault=%b, want level=%0d fr=%b dfr=%b fault=%b",
                             step, h, o.level, o.fr, o.dfr, o.fault, e.level, e.fr, e.dfr, e.fault);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        s1 = '0; s4 = '0; s8 = '0;
        test_reset();
        test_sequence();
        test_debounce();
        test_jump_fall_fault();
        test_reset_mid_debounce();
        test_ramp8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
